// File: rtl/pld_bft_pkg.sv
// -----------------------------------------------------------------------------
// pld_bft_pkg
// Shared definitions for the BFT leaf datapath: configuration opcodes, packet
// and config-payload field offsets, the control-register size computation
// (also used by data_ports) and the control_reg_loader state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package pld_bft_pkg;

    // Config payload opcodes
    localparam logic [7:0] CFG_OP_WRITE  = 8'h01;
    localparam logic [7:0] CFG_OP_COMMIT = 8'h02;
    localparam logic [7:0] CFG_OP_CLEAR  = 8'h03;

    // Config payload layout: opcode [63:56], chunk index [55:48], data [31:0]
    localparam int CFG_OPCODE_LSB  = 56;
    localparam int CFG_OPCODE_BITS = 8;
    localparam int CFG_INDEX_LSB   = 48;
    localparam int CFG_INDEX_BITS  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } cfg_state_e;

    // Port field sits directly above the payload.
    function automatic int port_lsb(input int payload_bits);
        return payload_bits;
    endfunction

    // Leaf field sits directly above the port field.
    function automatic int leaf_lsb(input int payload_bits, input int port_bits);
        return payload_bits + port_bits;
    endfunction

    // Each output port: leaf + port + two addresses + 3 flag bits;
    // each input port: leaf + port.
    function automatic int reg_control_bits(input int leaf_bits, input int port_bits,
                                            input int addr_bits, input int in_ports,
                                            input int out_ports);
        return (leaf_bits + port_bits + 2 * addr_bits + 3) * out_ports
             + (leaf_bits + port_bits) * in_ports;
    endfunction

    function automatic int num_chunks(input int reg_bits, input int chunk_bits);
        return (reg_bits + chunk_bits - 1) / chunk_bits;
    endfunction

endpackage

// File: rtl/cfg_chunk_shadow.sv
// -----------------------------------------------------------------------------
// cfg_chunk_shadow
// Shadow copy of the control register, filled one CHUNK_BITS chunk at a time,
// plus a per-chunk written mask. The final chunk only keeps the bits that fit
// inside REG_CONTROL_BITS; the rest of its data word is dropped.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   i_wr_en         write request (caller has already qualified the opcode)
//   i_wr_idx        chunk index of the write
//   i_wr_data       chunk data
//   i_clear_mask    clear the written mask (commit or CLEAR)
//   o_shadow        assembled shadow register
//   o_mask_full     every chunk has been written since the last mask clear
//   o_idx_ok        i_wr_idx addresses an existing chunk
// -----------------------------------------------------------------------------
module cfg_chunk_shadow
    import pld_bft_pkg::*;
#(
    parameter int CHUNK_BITS       = 32,
    parameter int REG_CONTROL_BITS = 259,
    parameter int NUM_CHUNKS       = 9,
    parameter int IDX_BITS         = CFG_INDEX_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_wr_en,
    input  logic [IDX_BITS-1:0]         i_wr_idx,
    input  logic [CHUNK_BITS-1:0]       i_wr_data,
    input  logic                        i_clear_mask,
    output logic [REG_CONTROL_BITS-1:0] o_shadow,
    output logic                        o_mask_full,
    output logic                        o_idx_ok
);

    localparam int LAST_BITS = REG_CONTROL_BITS - (NUM_CHUNKS - 1) * CHUNK_BITS;

    // Full-width chunks and the truncated top chunk are held separately so
    // no flop exists for bits beyond REG_CONTROL_BITS.
    logic [NUM_CHUNKS-2:0][CHUNK_BITS-1:0] r_full_chunks;
    logic [LAST_BITS-1:0]                  r_last_chunk;
    logic [NUM_CHUNKS-1:0]                 r_mask;
    logic [NUM_CHUNKS-1:0]                 w_sel;

    // One-hot chunk select; out-of-range indices select nothing, so shadow
    // and mask are left untouched for them.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (i_wr_en && (i_wr_idx == IDX_BITS'(k))) begin
                w_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_full_chunks <= '0;
            r_last_chunk  <= '0;
            r_mask        <= '0;
        end else begin
            for (int k = 0; k < NUM_CHUNKS - 1; k++) begin
                if (w_sel[k]) begin
                    r_full_chunks[k] <= i_wr_data;
                end
            end
            if (w_sel[NUM_CHUNKS-1]) begin
                r_last_chunk <= i_wr_data[LAST_BITS-1:0];
            end
            if (i_clear_mask) begin
                r_mask <= '0;
            end else begin
                r_mask <= r_mask | w_sel;
            end
        end
    end

    assign o_shadow    = {r_last_chunk, r_full_chunks};
    assign o_mask_full = &r_mask;
    assign o_idx_ok    = (i_wr_idx < IDX_BITS'(NUM_CHUNKS));

endmodule

// File: rtl/control_reg_loader.sv
// -----------------------------------------------------------------------------
// control_reg_loader
// Sits between the BFT leaf link and data_ports. Packets addressed to CFG_PORT
// are consumed as configuration commands that build a shadow control register;
// a successful COMMIT copies the shadow into o_control_reg in one edge, so the
// routing seen by data_ports never changes mid-load. Every other valid packet
// is forwarded unchanged one cycle later.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   i_stream        packet from the BFT leaf switch
//   o_stream        registered pass-through packet to data_ports
//   o_control_reg   active control register
//   o_cfg_done      one-cycle pulse on a successful commit
//   o_cfg_err       sticky error flag, cleared only by reset
//   o_loading       high while the loader FSM is in LOAD
// -----------------------------------------------------------------------------
module control_reg_loader
    import pld_bft_pkg::*;
#(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int PAYLOAD_BITS  = 64,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int CFG_PORT      = 0,
    parameter int CHUNK_BITS    = 32,
    localparam int REG_CONTROL_BITS = reg_control_bits(NUM_LEAF_BITS, NUM_PORT_BITS,
                                                       NUM_ADDR_BITS, NUM_IN_PORTS,
                                                       NUM_OUT_PORTS),
    localparam int NUM_CHUNKS = num_chunks(REG_CONTROL_BITS, CHUNK_BITS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PACKET_BITS-1:0]      i_stream,
    output logic [PACKET_BITS-1:0]      o_stream,
    output logic [REG_CONTROL_BITS-1:0] o_control_reg,
    output logic                        o_cfg_done,
    output logic                        o_cfg_err,
    output logic                        o_loading
);

    // Stream semantics: there is no ready/backpressure. A packet is present
    // when its top bit (valid) is 1 and is accepted on every clock edge; the
    // output stream carries the same valid-flag meaning, with an all-zero word
    // standing in for "no packet".

    cfg_state_e r_state;
    cfg_state_e w_state_next;

    logic [PACKET_BITS-1:0]      r_stream;
    logic [REG_CONTROL_BITS-1:0] r_control_reg;
    logic                        r_cfg_done;
    logic                        r_cfg_err;

    logic                        w_valid;
    logic [NUM_PORT_BITS-1:0]    w_port;
    logic                        w_is_cfg;
    logic [CFG_OPCODE_BITS-1:0]  w_opcode;
    logic [CFG_INDEX_BITS-1:0]   w_index;
    logic [CHUNK_BITS-1:0]       w_data;

    logic                        w_wr_en;
    logic                        w_clear_mask;
    logic                        w_commit;
    logic                        w_err;

    logic [REG_CONTROL_BITS-1:0] w_shadow;
    logic                        w_mask_full;
    logic                        w_idx_ok;

    // Field decode
    assign w_valid  = i_stream[PACKET_BITS-1];
    assign w_port   = i_stream[port_lsb(PAYLOAD_BITS) +: NUM_PORT_BITS];
    assign w_is_cfg = w_valid && (w_port == NUM_PORT_BITS'(CFG_PORT));
    assign w_opcode = i_stream[CFG_OPCODE_LSB +: CFG_OPCODE_BITS];
    assign w_index  = i_stream[CFG_INDEX_LSB +: CFG_INDEX_BITS];
    assign w_data   = i_stream[CHUNK_BITS-1:0];

    cfg_chunk_shadow #(
        .CHUNK_BITS       (CHUNK_BITS),
        .REG_CONTROL_BITS (REG_CONTROL_BITS),
        .NUM_CHUNKS       (NUM_CHUNKS),
        .IDX_BITS         (CFG_INDEX_BITS)
    ) u_shadow (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (w_index),
        .i_wr_data    (w_data),
        .i_clear_mask (w_clear_mask),
        .o_shadow     (w_shadow),
        .o_mask_full  (w_mask_full),
        .o_idx_ok     (w_idx_ok)
    );

    // Command decode and next state. A COMMIT is judged only on the mask:
    // in IDLE the mask is always empty, so an IDLE commit fails naturally.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_clear_mask = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        if (w_is_cfg) begin
            case (w_opcode)
                CFG_OP_WRITE: begin
                    if (w_idx_ok) begin
                        w_wr_en      = 1'b1;
                        w_state_next = ST_LOAD;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                CFG_OP_COMMIT: begin
                    if (w_mask_full) begin
                        w_commit     = 1'b1;
                        w_clear_mask = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                CFG_OP_CLEAR: begin
                    w_clear_mask = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_err = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_stream      <= '0;
            r_control_reg <= '0;
            r_cfg_done    <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            // Config packets and empty slots both leave a zero word behind.
            r_stream      <= (w_valid && !w_is_cfg) ? i_stream : '0;
            if (w_commit) begin
                r_control_reg <= w_shadow;
            end
            r_cfg_done    <= w_commit;
            r_cfg_err     <= r_cfg_err | w_err;
        end
    end

    assign o_stream      = r_stream;
    assign o_control_reg = r_control_reg;
    assign o_cfg_done    = r_cfg_done;
    assign o_cfg_err     = r_cfg_err;
    assign o_loading     = (r_state == ST_LOAD);

endmodule

// File: tb/tb_control_reg_loader.sv
// -----------------------------------------------------------------------------
// tb_control_reg_loader
// Directed bench for control_reg_loader at default parameters.
// -----------------------------------------------------------------------------
module tb_control_reg_loader;

    localparam int PB  = 97;
    localparam int RCB = 259;

    logic           clk;
    logic           reset;
    logic [PB-1:0]  i_stream;
    logic [PB-1:0]  o_stream;
    logic [RCB-1:0] o_control_reg;
    logic           o_cfg_done;
    logic           o_cfg_err;
    logic           o_loading;

    int n_checks;
    int n_fail;

    logic [PB-1:0]  exp_q[$];
    logic [31:0]    chunk_m[9];
    logic [RCB-1:0] saved_ctrl;

    control_reg_loader dut (
        .clk           (clk),
        .reset         (reset),
        .i_stream      (i_stream),
        .o_stream      (o_stream),
        .o_control_reg (o_control_reg),
        .o_cfg_done    (o_cfg_done),
        .o_cfg_err     (o_cfg_err),
        .o_loading     (o_loading)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PB-1:0] mk_pkt(input logic v, input logic [21:0] hi,
                                             input logic [5:0] leaf, input logic [3:0] port,
                                             input logic [63:0] pl);
        return {v, hi, leaf, port, pl};
    endfunction

    function automatic logic [PB-1:0] mk_cfg(input logic [7:0] op, input logic [7:0] idx,
                                             input logic [31:0] data);
        return mk_pkt(1'b1, 22'h0, 6'h0, 4'h0, {op, idx, 16'h0, data});
    endfunction

    // Expected register image from the chunk model; the top chunk is truncated.
    function automatic logic [RCB-1:0] exp_ctrl();
        logic [287:0] t;
        t = '0;
        for (int k = 0; k < 9; k++) t[k*32 +: 32] = chunk_m[k];
        return t[RCB-1:0];
    endfunction

    // Drive one packet across one active edge; outputs are then sampled 1 ns later.
    task automatic cycle(input logic [PB-1:0] pkt);
        i_stream = pkt;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        cycle('0);
        reset = 1'b1;
    endtask

    task automatic write_chunk(input int k, input logic [31:0] d);
        chunk_m[k] = d;
        cycle(mk_cfg(8'h01, 8'(k), d));
    endtask

    initial begin
        logic [PB-1:0] p;
        logic [PB-1:0] e;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        i_stream = '0;
        for (int k = 0; k < 9; k++) chunk_m[k] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_stream", o_stream, 0);
        check("rst_ctrl", o_control_reg, 0);
        check("rst_done", o_cfg_done, 0);
        check("rst_err", o_cfg_err, 0);
        check("rst_loading", o_loading, 0);
        reset = 1'b1;

        // Pass-through, bit-identical including the upper header bits
        p = mk_pkt(1'b1, 22'h15A5A5, 6'h2A, 4'd3, 64'hDEADBEEF_CAFEF00D);
        cycle(p);
        check("pt_stream", o_stream, p);
        check("pt_ctrl", o_control_reg, 0);
        cycle(mk_pkt(1'b0, 22'h3, 6'h1, 4'd3, 64'h1234));
        check("pt_invalid_zero", o_stream, 0);

        // Full load then commit
        for (int k = 0; k < 9; k++) begin
            write_chunk(k, 32'h11111111 * (k + 1));
            check("load_stream_zero", o_stream, 0);
            check("load_loading", o_loading, 1);
            check("load_no_done", o_cfg_done, 0);
        end
        check("load_ctrl_hold", o_control_reg, 0);
        cycle(mk_cfg(8'h02, 8'h0, 32'h0));
        check("commit_done", o_cfg_done, 1);
        check("commit_ctrl", o_control_reg, exp_ctrl());
        check("commit_low", o_control_reg[31:0], 32'h11111111);
        check("commit_top", o_control_reg[258:256], 3'b001);
        check("commit_stream_zero", o_stream, 0);
        check("commit_idle", o_loading, 0);
        check("commit_err", o_cfg_err, 0);
        cycle('0);
        check("done_pulse_end", o_cfg_done, 0);
        saved_ctrl = o_control_reg;
        check("ctrl_holds", o_control_reg, exp_ctrl());

        // Incomplete commit
        for (int k = 0; k < 8; k++) write_chunk(k, 32'hA5A50000 + k);
        cycle(mk_cfg(8'h02, 8'h0, 32'h0));
        check("inc_err", o_cfg_err, 1);
        check("inc_no_done", o_cfg_done, 0);
        check("inc_ctrl_hold", o_control_reg, saved_ctrl);
        check("inc_loading", o_loading, 1);
        write_chunk(8, 32'hFFFFFFF6);
        check("inc_last_loading", o_loading, 1);
        cycle(mk_cfg(8'h02, 8'h0, 32'h0));
        check("inc2_done", o_cfg_done, 1);
        check("inc2_ctrl", o_control_reg, exp_ctrl());
        check("inc2_top", o_control_reg[258:256], 3'b110);
        check("inc2_err_sticky", o_cfg_err, 1);

        // Out-of-range index
        apply_reset();
        check("rst2_err", o_cfg_err, 0);
        check("rst2_ctrl", o_control_reg, 0);
        cycle(mk_cfg(8'h01, 8'd9, 32'hBAD0BAD0));
        check("oor_err", o_cfg_err, 1);
        check("oor_idle", o_loading, 0);
        for (int k = 0; k < 9; k++) write_chunk(k, 32'h01020304 << k);
        cycle(mk_cfg(8'h02, 8'h0, 32'h0));
        check("oor_commit_done", o_cfg_done, 1);
        check("oor_commit_ctrl", o_control_reg, exp_ctrl());

        // Unknown opcode
        apply_reset();
        cycle(mk_cfg(8'h7F, 8'h0, 32'h0));
        check("unk_err", o_cfg_err, 1);
        check("unk_idle", o_loading, 0);
        check("unk_stream_zero", o_stream, 0);
        check("unk_ctrl", o_control_reg, 0);

        // Interleaved config writes and port-5 data
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                exp_q.push_back('0);
                write_chunk(i / 2, $urandom);
            end else begin
                p = mk_pkt(1'b1, 22'($urandom), 6'($urandom), 4'd5, {$urandom, $urandom});
                exp_q.push_back(p);
                cycle(p);
            end
            e = exp_q.pop_front();
            check("ilv_stream", o_stream, e);
        end
        cycle('0);
        check("ilv_tail_zero", o_stream, 0);
        check("ilv_loading", o_loading, 1);
        check("ilv_err", o_cfg_err, 0);
        for (int k = 5; k < 9; k++) write_chunk(k, $urandom);
        cycle(mk_cfg(8'h02, 8'h0, 32'h0));
        check("ilv_commit_ctrl", o_control_reg, exp_ctrl());

        // Reset mid-load
        for (int k = 0; k < 5; k++) write_chunk(k, 32'h5A5A0000 + k);
        check("mid_loading", o_loading, 1);
        apply_reset();
        check("mid_rst_idle", o_loading, 0);
        check("mid_rst_ctrl", o_control_reg, 0);
        check("mid_rst_err", o_cfg_err, 0);
        cycle(mk_cfg(8'h02, 8'h0, 32'h0));
        check("mid_commit_err", o_cfg_err, 1);
        check("mid_commit_no_done", o_cfg_done, 0);
        check("mid_commit_ctrl", o_control_reg, 0);

        // CLEAR
        apply_reset();
        for (int k = 0; k < 5; k++) write_chunk(k, 32'hC0DE0000 + k);
        cycle(mk_cfg(8'h03, 8'h0, 32'h0));
        check("clr_idle", o_loading, 0);
        check("clr_no_err", o_cfg_err, 0);
        check("clr_ctrl", o_control_reg, 0);
        cycle(mk_cfg(8'h02, 8'h0, 32'h0));
        check("clr_commit_err", o_cfg_err, 1);
        check("clr_commit_no_done", o_cfg_done, 0);
        check("clr_commit_ctrl", o_control_reg, 0);
        cycle(mk_cfg(8'h03, 8'h0, 32'h0));
        check("clr_err_sticky", o_cfg_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
